// File: rtl/apb_bridge_pkg.sv
// Shared types and constants for the APB-to-memory bridge.
package apb_bridge_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      MEM  = 2'd1,
      RESP = 2'd2
   } state_t;

   localparam logic ERR_OK  = 1'b0;
   localparam logic ERR_SLV = 1'b1;

   // Counter width large enough for the longer of the timeout and fixed-latency windows.
   function automatic int cnt_width(input int a, input int b);
      return $clog2((a > b) ? a : b) + 1;
   endfunction

endpackage

// File: rtl/apb_wait_counter.sv
// Saturating wait counter: cleared outside the memory phase, counts memory-phase
// cycles, and flags the terminal count (fixed latency or timeout window).
module apb_wait_counter #(
   parameter int CNT_W = 4,
   parameter int TERM  = 1
) (
   input  logic clk,
   input  logic reset,
   input  logic clear,
   input  logic enable,
   output logic done
);

   logic [CNT_W-1:0] count;

   // Count memory-phase cycles, holding at all-ones rather than wrapping.
   always_ff @(posedge clk) begin
      if (reset || clear) begin
         count <= '0;
      end else if (enable && (count != '1)) begin
         count <= count + 1'b1;
      end
   end

   assign done = (count == CNT_W'(TERM - 1));

endmodule

// File: rtl/apb_mem_bridge.sv
// APB3 slave bridging one select code to a generic memory/peripheral port.
// Optional feature: define APB_TIMEOUT_EN to abort ack-mode accesses that see no
// mem_ack within TIMEOUT cycles (answered with pslverr=1, prdata=0).
//
// Handshake: a transfer is accepted in IDLE on the setup phase (psel==id, id!=0,
// penable low). mem_req stays high, with mem_we/mem_addr/mem_wdata stable, until
// mem_ack (ACK_MODE=1), FIXED_LAT cycles (ACK_MODE=0) or the timeout. pready is a
// single-cycle pulse; prdata and pslverr are only meaningful while pready is high.
module apb_mem_bridge
   import apb_bridge_pkg::*;
#(
   parameter int ADDR_W    = 8,
   parameter int DATA_W    = 8,
   parameter int SEL_W     = 2,
   parameter int MEM_DEPTH = 256,
   parameter int ACK_MODE  = 1,
   parameter int FIXED_LAT = 1,
   parameter int TIMEOUT   = 64
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [SEL_W-1:0]  id,
   input  logic [SEL_W-1:0]  psel,
   input  logic              penable,
   input  logic              pwrite,
   input  logic [ADDR_W-1:0] paddr,
   input  logic [DATA_W-1:0] pwdata,
   output logic [DATA_W-1:0] prdata,
   output logic              pready,
   output logic              pslverr,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   input  logic              mem_ack,
   output state_t            state
);

   localparam int CNT_W = cnt_width(TIMEOUT, FIXED_LAT);
   localparam int TERM  = (ACK_MODE != 0) ? TIMEOUT : FIXED_LAT;

   state_t            state_nx;
   logic              we_q;
   logic [ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0] wdata_q;
   logic [DATA_W-1:0] rdata_q;
   logic              err_q;
   logic              dropped_q;
   logic              cnt_done;
   logic              selected;
   logic              hit;
   logic              range_err;
   logic              mem_done;
   logic              mem_to;

   assign selected  = (psel == id);
   assign hit       = selected && (id != '0) && !penable;
   assign range_err = (32'(paddr) >= 32'(MEM_DEPTH));
   assign mem_done  = (ACK_MODE != 0) ? mem_ack : cnt_done;
`ifdef APB_TIMEOUT_EN
   assign mem_to    = (ACK_MODE != 0) && cnt_done && !mem_ack;
`else
   assign mem_to    = 1'b0;
`endif

   apb_wait_counter #(
      .CNT_W (CNT_W),
      .TERM  (TERM)
   ) u_wait_counter (
      .clk    (clk),
      .reset  (reset),
      .clear  (state != MEM),
      .enable (state == MEM),
      .done   (cnt_done)
   );

   // State register.
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_nx;
      end
   end

   // Next state: out-of-range skips the memory; an abandoned transfer skips the response.
   always_comb begin
      state_nx = state;
      case (state)
         IDLE: if (hit) state_nx = range_err ? RESP : MEM;
         MEM:  if (mem_done || mem_to) state_nx = (dropped_q || !selected) ? IDLE : RESP;
         RESP: state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // Capture the request on acceptance and the response when the memory phase ends.
   always_ff @(posedge clk) begin
      if (reset) begin
         we_q      <= 1'b0;
         addr_q    <= '0;
         wdata_q   <= '0;
         rdata_q   <= '0;
         err_q     <= ERR_OK;
         dropped_q <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               dropped_q <= 1'b0;
               if (hit) begin
                  we_q    <= pwrite;
                  addr_q  <= paddr;
                  wdata_q <= pwdata;
                  rdata_q <= '0;
                  err_q   <= range_err ? ERR_SLV : ERR_OK;
               end
            end
            MEM: begin
               if (!selected) dropped_q <= 1'b1;
               if (mem_done) begin
                  if (!we_q) rdata_q <= mem_rdata;
               end else if (mem_to) begin
                  rdata_q <= '0;
                  err_q   <= ERR_SLV;
               end
            end
            default: ;
         endcase
      end
   end

   // Outputs decoded from state plus captured registers.
   always_comb begin
      mem_req   = (state == MEM);
      pready    = (state == RESP);
      pslverr   = (state == RESP) && (err_q == ERR_SLV);
      prdata    = (state == RESP) ? rdata_q : '0;
      mem_we    = we_q;
      mem_addr  = addr_q;
      mem_wdata = wdata_q;
   end

endmodule

// File: tb/tb_apb_mem_bridge.sv
// Bench for apb_mem_bridge: one ack-mode slave (id 2) and one fixed-latency slave
// (id 1, MEM_DEPTH 16) share an APB bus. Drivers write a per-cycle expected timeline
// derived from the transfer latency rules; a negedge process compares every cycle.
module tb_apb_mem_bridge;
   import apb_bridge_pkg::*;

   localparam int N = 1024;

   typedef struct {
      bit       req;
      bit       we;
      bit [7:0] addr;
      bit [7:0] wdata;
      bit       rdy;
      bit       err;
      bit [7:0] rdata;
   } exp_t;

   exp_t exp_a [N];
   exp_t exp_f [N];

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [1:0] id_a = 2'd2;
   logic [1:0] id_f = 2'd1;
   logic [1:0] psel = 2'd0;
   logic       penable = 1'b0;
   logic       pwrite = 1'b0;
   logic [7:0] paddr = 8'h00;
   logic [7:0] pwdata = 8'h00;
   logic [7:0] mem_rdata_a = 8'h00;
   logic [7:0] mem_rdata_f = 8'h00;
   logic       mem_ack_a = 1'b0;
   logic       mem_ack_f = 1'b0;

   logic [7:0] prdata_a, prdata_f, mem_addr_a, mem_addr_f, mem_wdata_a, mem_wdata_f;
   logic       pready_a, pready_f, pslverr_a, pslverr_f;
   logic       mem_req_a, mem_req_f, mem_we_a, mem_we_f;
   state_t     state_a, state_f;

   int cyc = 0;
   int checks = 0;
   int errors = 0;
   int t_wr = -100;
   int t_rd = -100;
   int t_rng = -100;
   int t_rst = -100;

   apb_mem_bridge #(.ACK_MODE(1), .TIMEOUT(8)) u_ack (
      .clk(clk), .reset(reset), .id(id_a), .psel(psel), .penable(penable),
      .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata), .prdata(prdata_a),
      .pready(pready_a), .pslverr(pslverr_a), .mem_req(mem_req_a), .mem_we(mem_we_a),
      .mem_addr(mem_addr_a), .mem_wdata(mem_wdata_a), .mem_rdata(mem_rdata_a),
      .mem_ack(mem_ack_a), .state(state_a)
   );

   apb_mem_bridge #(.MEM_DEPTH(16), .ACK_MODE(0), .FIXED_LAT(3)) u_fix (
      .clk(clk), .reset(reset), .id(id_f), .psel(psel), .penable(penable),
      .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata), .prdata(prdata_f),
      .pready(pready_f), .pslverr(pslverr_f), .mem_req(mem_req_f), .mem_we(mem_we_f),
      .mem_addr(mem_addr_f), .mem_wdata(mem_wdata_f), .mem_rdata(mem_rdata_f),
      .mem_ack(mem_ack_f), .state(state_f)
   );

   // Clock and cycle index.
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s cyc=%0d actual=%0h required=%0h", nm, cyc, act, exp);
      end
   endtask

   task automatic cmp_side(input string tag, input exp_t e, input logic req, input logic we,
                           input logic [7:0] addr, input logic [7:0] wdata, input logic rdy,
                           input logic err, input logic [7:0] rdata, input state_t st);
      state_t es;
      es = e.req ? MEM : (e.rdy ? RESP : IDLE);
      chk({tag, "_mem_req"}, 32'(req), 32'(e.req));
      chk({tag, "_pready"}, 32'(rdy), 32'(e.rdy));
      chk({tag, "_state"}, 32'(st), 32'(es));
      if (e.req) begin
         chk({tag, "_mem_we"}, 32'(we), 32'(e.we));
         chk({tag, "_mem_addr"}, 32'(addr), 32'(e.addr));
         chk({tag, "_mem_wdata"}, 32'(wdata), 32'(e.wdata));
      end
      if (e.rdy) begin
         chk({tag, "_pslverr"}, 32'(err), 32'(e.err));
         chk({tag, "_prdata"}, 32'(rdata), 32'(e.rdata));
      end
   endtask

   // Compare process: model timeline every cycle, plus literal pins of the model.
   always @(negedge clk) begin
      if (cyc >= 1 && cyc < N) begin
         cmp_side("ack", exp_a[cyc], mem_req_a, mem_we_a, mem_addr_a, mem_wdata_a,
                  pready_a, pslverr_a, prdata_a, state_a);
         cmp_side("fix", exp_f[cyc], mem_req_f, mem_we_f, mem_addr_f, mem_wdata_f,
                  pready_f, pslverr_f, prdata_f, state_f);
      end
      if (cyc == 2) begin
         chk("lit_rst_addr", 32'(mem_addr_a), 32'h0);
         chk("lit_rst_we", 32'(mem_we_a), 32'h0);
         chk("lit_rst_prdata", 32'(prdata_f), 32'h0);
      end
      if (cyc == t_wr + 1) begin
         chk("lit_wr_addr", 32'(mem_addr_a), 32'h10);
         chk("lit_wr_wdata", 32'(mem_wdata_a), 32'hA5);
         chk("lit_wr_we", 32'(mem_we_a), 32'h1);
      end
      if (cyc == t_wr + 3) begin
         chk("lit_wr_pready", 32'(pready_a), 32'h1);
         chk("lit_wr_pslverr", 32'(pslverr_a), 32'h0);
      end
      if (cyc == t_rd + 3) chk("lit_rd_req_last", 32'(mem_req_f), 32'h1);
      if (cyc == t_rd + 4) begin
         chk("lit_rd_req_off", 32'(mem_req_f), 32'h0);
         chk("lit_rd_pready", 32'(pready_f), 32'h1);
         chk("lit_rd_prdata", 32'(prdata_f), 32'h3C);
      end
      if (cyc == t_rng + 1) begin
         chk("lit_rng_req", 32'(mem_req_f), 32'h0);
         chk("lit_rng_pready", 32'(pready_f), 32'h1);
         chk("lit_rng_pslverr", 32'(pslverr_f), 32'h1);
         chk("lit_rng_prdata", 32'(prdata_f), 32'h0);
      end
      if (cyc == t_rst + 2) begin
         chk("lit_rst_mid_req", 32'(mem_req_a), 32'h0);
         chk("lit_rst_mid_state", 32'(state_a), 32'(IDLE));
      end
   end

   // Advance one cycle; refresh don't-care memory inputs with noise.
   task automatic tick();
      @(posedge clk);
      #1;
      mem_ack_f   = 1'($urandom_range(0, 1));
      mem_rdata_a = 8'($urandom_range(0, 255));
      mem_rdata_f = 8'($urandom_range(0, 255));
   endtask

   task automatic setup(input logic [1:0] sel, input bit we, input bit [7:0] addr, input bit [7:0] wd);
      psel = sel; penable = 1'b0; pwrite = we; paddr = addr; pwdata = wd;
   endtask

   // Ack-mode transfer: ack k cycles after mem_req rises; drop=1 abandons after one access cycle.
   task automatic xfer_a(input bit we, input bit [7:0] addr, input bit [7:0] wd,
                         input bit [7:0] rd, input int k, input bit drop);
      int t;
      t = cyc;
      setup(2'd2, we, addr, wd);
      for (int i = 0; i <= k; i++) begin
         exp_a[t+1+i].req = 1'b1; exp_a[t+1+i].we = we;
         exp_a[t+1+i].addr = addr; exp_a[t+1+i].wdata = wd;
      end
      if (!drop) begin
         exp_a[t+2+k].rdy = 1'b1; exp_a[t+2+k].err = 1'b0;
         exp_a[t+2+k].rdata = we ? 8'h00 : rd;
      end
      tick();
      penable = 1'b1;
      while (cyc < t + 2 + k) begin
         if (drop && cyc >= t + 2) begin psel = 2'd0; penable = 1'b0; end
         if (cyc == t + 1 + k) begin mem_ack_a = 1'b1; mem_rdata_a = rd; end
         else mem_ack_a = 1'b0;
         tick();
      end
      mem_ack_a = 1'b0;
      if (!drop) begin
         tick();
         psel = 2'd0; penable = 1'b0;
      end
   endtask

   // Fixed-latency (3 cycle) transfer on the MEM_DEPTH=16 slave.
   task automatic xfer_f(input bit we, input bit [7:0] addr, input bit [7:0] wd, input bit [7:0] rd);
      int t;
      t = cyc;
      setup(2'd1, we, addr, wd);
      if (addr >= 8'd16) begin
         exp_f[t+1].rdy = 1'b1; exp_f[t+1].err = 1'b1; exp_f[t+1].rdata = 8'h00;
         tick(); penable = 1'b1;
         tick();
      end else begin
         for (int i = 1; i <= 3; i++) begin
            exp_f[t+i].req = 1'b1; exp_f[t+i].we = we;
            exp_f[t+i].addr = addr; exp_f[t+i].wdata = wd;
         end
         exp_f[t+4].rdy = 1'b1; exp_f[t+4].err = 1'b0; exp_f[t+4].rdata = we ? 8'h00 : rd;
         tick(); penable = 1'b1;
         tick();
         tick(); mem_rdata_f = rd;
         tick();
         tick();
      end
      psel = 2'd0; penable = 1'b0;
   endtask

   initial begin
      int t;
      repeat (3) tick();
      reset = 1'b0;
      tick();

      t_wr = cyc;
      xfer_a(1'b1, 8'h10, 8'hA5, 8'h00, 1, 1'b0);
      xfer_a(1'b0, 8'h10, 8'h00, 8'h5A, 0, 1'b0);
      xfer_a(1'b0, 8'hFF, 8'h00, 8'hC3, 3, 1'b0);
      t_rd = cyc;
      xfer_f(1'b0, 8'h05, 8'h00, 8'h3C);
      xfer_f(1'b1, 8'h0F, 8'h77, 8'h00);
      xfer_f(1'b0, 8'h10, 8'h00, 8'h11);
      t_rng = cyc;
      xfer_f(1'b0, 8'h20, 8'h00, 8'h22);
      xfer_a(1'b1, 8'h33, 8'h44, 8'h00, 2, 1'b1);
      xfer_a(1'b0, 8'h33, 8'h00, 8'h96, 0, 1'b0);

`ifdef APB_TIMEOUT_EN
      t = cyc;
      setup(2'd2, 1'b0, 8'h40, 8'h00);
      for (int i = 1; i <= 8; i++) begin
         exp_a[t+i].req = 1'b1; exp_a[t+i].we = 1'b0; exp_a[t+i].addr = 8'h40; exp_a[t+i].wdata = 8'h00;
      end
      exp_a[t+9].rdy = 1'b1; exp_a[t+9].err = 1'b1; exp_a[t+9].rdata = 8'h00;
      tick(); penable = 1'b1;
      repeat (8) tick();
      mem_ack_a = 1'b1; mem_rdata_a = 8'hEE;
      tick();
      psel = 2'd0; penable = 1'b0;
      tick();
      mem_ack_a = 1'b0;
      tick();
`else
      xfer_a(1'b0, 8'h40, 8'h00, 8'h6B, 20, 1'b0);
`endif

      // Unselected codes: id 0 with psel 0, and a code nobody owns; stray acks ignored.
      id_a = 2'd0;
      setup(2'd0, 1'b1, 8'h01, 8'h55);
      mem_ack_a = 1'b1;
      tick(); tick();
      id_a = 2'd2;
      setup(2'd3, 1'b1, 8'h02, 8'h66);
      tick(); tick();
      mem_ack_a = 1'b0;
      psel = 2'd0;
      tick();

      // Reset during the memory phase.
      t = cyc;
      t_rst = t;
      setup(2'd2, 1'b1, 8'h44, 8'h99);
      exp_a[t+1].req = 1'b1; exp_a[t+1].we = 1'b1; exp_a[t+1].addr = 8'h44; exp_a[t+1].wdata = 8'h99;
      tick(); penable = 1'b1; reset = 1'b1;
      tick(); reset = 1'b0; psel = 2'd0; penable = 1'b0;
      tick();

      xfer_a(1'b0, 8'h44, 8'h00, 8'h81, 1, 1'b0);
      xfer_f(1'b0, 8'h0A, 8'h00, 8'hB7);
      repeat (3) tick();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
